// File: rtl/eparity_tx32.sv
// eparity_tx32: even-parity serial frame transmitter; shifts {data, parity} out MSB-first with valid/ready backpressure.
// Optional build macro EPARITY_TX_ERRINJ_EN adds err_inject, which inverts the parity bit of the accepted frame.
module eparity_tx32 #(
   parameter int DATA_W = 31,
   parameter int CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              tx_bit,
   output logic              tx_valid,
   input  logic              tx_ready,
`ifdef EPARITY_TX_ERRINJ_EN
   input  logic              err_inject,
`endif
   output logic              tx_last,
   output logic [DATA_W:0]   frame,
   output logic [CNT_W-1:0]  one_count
);

   localparam int FW    = DATA_W + 1;
   localparam int IDX_W = $clog2(FW);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(FW - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      logic p;
      p = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         p = p ^ d[i];
      end
      return p;
   endfunction

   function automatic logic [CNT_W-1:0] pop_count(input logic [DATA_W-1:0] d);
      logic [CNT_W-1:0] c;
      c = {CNT_W{1'b0}};
      for (int i = 0; i < DATA_W; i++) begin
         c = c + CNT_W'(d[i]);
      end
      return c;
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic [IDX_W-1:0]   w_idx_dec;
   logic [FW-1:0]      r_frame;
   logic [FW-1:0]      w_frame_nxt;
   logic [CNT_W-1:0]   r_one_count;
   logic [CNT_W-1:0]   w_one_nxt;
   logic               r_tx_bit;
   logic               w_bit_nxt;
   logic               r_tx_valid;
   logic               w_valid_nxt;
   logic               r_tx_last;
   logic               w_last_nxt;
   logic               w_par;
   logic               w_beat;
   logic               w_done;
   logic               w_in_ready;
   logic               w_accept;

`ifdef EPARITY_TX_ERRINJ_EN
   assign w_par = even_parity(in_data) ^ err_inject;
`else
   assign w_par = even_parity(in_data);
`endif

   // A new word may be taken in the same cycle the parity bit is consumed, so frames run back to back.
   assign w_beat     = (r_state == ST_SHIFT) && tx_ready;
   assign w_done     = w_beat && r_tx_last;
   assign w_in_ready = (r_state == ST_IDLE) || w_done;
   assign w_accept   = in_valid && w_in_ready;
   assign w_idx_dec  = r_idx - IDX_ONE;

   // Next-state and next-output computation; the serial bit is pre-selected so tx_bit comes from a flop.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_frame_nxt = r_frame;
      w_one_nxt   = r_one_count;
      w_bit_nxt   = r_tx_bit;
      w_last_nxt  = r_tx_last;
      if (w_accept) begin
         w_state_nxt = ST_SHIFT;
         w_idx_nxt   = IDX_TOP;
         w_frame_nxt = {in_data, w_par};
         w_one_nxt   = pop_count(in_data);
         w_bit_nxt   = in_data[DATA_W-1];
         w_last_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
               if (w_done) begin
                  w_state_nxt = ST_IDLE;
                  w_bit_nxt   = 1'b0;
                  w_last_nxt  = 1'b0;
               end else if (w_beat) begin
                  w_idx_nxt  = w_idx_dec;
                  w_bit_nxt  = r_frame[w_idx_dec];
                  w_last_nxt = (w_idx_dec == IDX_ZERO);
               end else begin
                  w_state_nxt = ST_SHIFT;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_bit_nxt   = 1'b0;
               w_last_nxt  = 1'b0;
            end
         endcase
      end
      w_valid_nxt = (w_state_nxt == ST_SHIFT);
   end

   // State and output registers with synchronous active-low reset; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= IDX_TOP;
         r_frame     <= {FW{1'b0}};
         r_one_count <= {CNT_W{1'b0}};
         r_tx_bit    <= 1'b0;
         r_tx_valid  <= 1'b0;
         r_tx_last   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_frame     <= w_frame_nxt;
         r_one_count <= w_one_nxt;
         r_tx_bit    <= w_bit_nxt;
         r_tx_valid  <= w_valid_nxt;
         r_tx_last   <= w_last_nxt;
      end
   end

   assign in_ready  = w_in_ready;
   assign tx_bit    = r_tx_bit;
   assign tx_valid  = r_tx_valid;
   assign tx_last   = r_tx_last;
   assign frame     = r_frame;
   assign one_count = r_one_count;

endmodule

// File: tb/tb_eparity_tx32.sv
// Self-checking bench for eparity_tx32: scoreboard of expected frames, serial collection and handshake checks.
module tb_eparity_tx32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [30:0] in_data;
   logic        in_ready;
   logic        tx_bit;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        tx_last;
   logic [31:0] frame;
   logic [4:0]  one_count;
   logic        err_v;
   logic        bp = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] f;
      logic [4:0]  c;
   } exp_t;
   exp_t sb_q[$];

   int          nbits = 0;
   logic [31:0] col = 32'h0;
   logic        held_v = 1'b0;
   logic        held_bit = 1'b0;

   eparity_tx32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .tx_bit    (tx_bit),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
`ifdef EPARITY_TX_ERRINJ_EN
      .err_inject(err_v),
`endif
      .tx_last   (tx_last),
      .frame     (frame),
      .one_count (one_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [30:0] w, input logic e);
      exp_t r;
      logic p;
      p = 1'b0;
      r.c = 5'd0;
      for (int i = 0; i < 31; i++) begin
         p = p ^ w[i];
         r.c = r.c + 5'(w[i]);
      end
`ifdef EPARITY_TX_ERRINJ_EN
      r.f = {w, p ^ e};
`else
      r.f = {w, p};
      if (e) r.f = {w, p};
`endif
      return r;
   endfunction

   // Downstream monitor: collects bits, compares against the scoreboard, checks handshake rules.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sb_q.delete();
         nbits = 0;
         col = 32'h0;
         held_v = 1'b0;
      end else begin
         check_eq("in_ready_rule", 32'(in_ready), 32'(!tx_valid || (tx_last && tx_ready)));
         if (held_v) begin
            check_eq("hold_valid", 32'(tx_valid), 32'd1);
            check_eq("hold_bit", 32'(tx_bit), 32'(held_bit));
         end
         if (nbits != 0) check_eq("mid_frame_valid", 32'(tx_valid), 32'd1);
         held_v = tx_valid && !tx_ready;
         held_bit = tx_bit;
         if (tx_valid && tx_ready) begin
            col = {col[30:0], tx_bit};
            nbits++;
            check_eq("last_pos", 32'(tx_last), 32'(nbits == 32));
            if (tx_last) begin
               if (sb_q.size() == 0) begin
                  check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
               end else begin
                  e = sb_q.pop_front();
                  check_eq("stream", col, e.f);
                  check_eq("frame_out", frame, e.f);
                  check_eq("one_count", 32'(one_count), 32'(e.c));
               end
               nbits = 0;
            end
         end
         if (in_valid && in_ready) sb_q.push_back(model(in_data, err_v));
      end
   end

   // Downstream ready: always 1, or ~50% random while backpressure is enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send(input logic [30:0] w, input logic e);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data = w;
      err_v = e;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 500);
      check_eq("accept_timeout", 32'(n < 500), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      err_v = 1'b0;
      in_data = 31'($urandom);
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((tx_valid || sb_q.size() != 0) && n < limit);
      check_eq("done_timeout", 32'(n < limit), 32'd1);
   endtask

   initial begin
      int n;
      int vcnt;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = 31'h0;
      err_v = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
      check_eq("rst_tx_bit", 32'(tx_bit), 32'd0);
      check_eq("rst_tx_last", 32'(tx_last), 32'd0);
      check_eq("rst_frame", frame, 32'h0);
      check_eq("rst_one_count", 32'(one_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);

      // Basic frame with continuous ready: tx_valid high for exactly 32 cycles.
      send(31'h0000002A, 1'b0);
      vcnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!tx_valid) break;
         vcnt++;
      end
      check_eq("t1_valid_cycles", 32'(vcnt), 32'd32);
      check_eq("t1_frame", frame, 32'h00000055);
      check_eq("t1_ones", 32'(one_count), 32'd3);

      send(31'h00000155, 1'b0);
      wait_done(200);
      check_eq("t2_frame", frame, 32'h000002AB);
      check_eq("t2_parity", 32'(frame[0]), 32'd1);
      check_eq("t2_ones", 32'(one_count), 32'd5);
      send(31'h00000000, 1'b0);
      wait_done(200);
      check_eq("t2z_frame", frame, 32'h0);
      check_eq("t2z_ones", 32'(one_count), 32'd0);

      // Back-to-back frames with in_valid held.
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data = 31'h7FFFFFFF;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 100);
      @(posedge clk);
      #1;
      in_data = 31'h40000000;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 100);
      check_eq("t3_ready_wait", 32'(n), 32'd32);
      check_eq("t3_ready_on_last", 32'(tx_last), 32'd1);
      check_eq("t3_frame_a", frame, 32'hFFFFFFFF);
      check_eq("t3_ones_a", 32'(one_count), 32'd31);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("t3_no_gap", 32'(tx_valid), 32'd1);
      check_eq("t3_frame_b", frame, 32'h80000001);
      check_eq("t3_first_bit_b", 32'(tx_bit), 32'd1);
      check_eq("t3_ones_b", 32'(one_count), 32'd1);
      wait_done(200);

      // Random backpressure.
      bp = 1'b1;
      send(31'h12345678, 1'b0);
      wait_done(2000);
      bp = 1'b0;
      check_eq("t4_frame", frame, 32'h2468ACF1);
      check_eq("t4_ones", 32'(one_count), 32'd13);

      // Reset after 10 consumed bits.
      send(31'h0ABCDEF5, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (nbits != 10 && n < 100);
      check_eq("t5_reach_10", 32'(nbits), 32'd10);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("t5_valid", 32'(tx_valid), 32'd0);
      check_eq("t5_frame", frame, 32'h0);
      check_eq("t5_in_ready", 32'(in_ready), 32'd1);
      send(31'h00000001, 1'b0);
      wait_done(200);
      check_eq("t5_frame_new", frame, 32'h00000003);

`ifdef EPARITY_TX_ERRINJ_EN
      send(31'h0000002A, 1'b1);
      wait_done(200);
      check_eq("t6_frame", frame, 32'h00000054);
      check_eq("t6_ones", 32'(one_count), 32'd3);
      check_eq("t6_confirm", 32'(~^frame), 32'd0);
`endif

      repeat (5) @(negedge clk);
      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/eparity_tx32.md
Name: eparity_tx32

Overview:
- Even-parity serial frame transmitter; the sending end for the even-parity checker's 32-bit frames.
- Accepts a DATA_W-bit word over a valid/ready handshake and appends an even-parity bit at frame bit 0.
- Shifts the DATA_W+1-bit frame out MSB-first, one bit per accepted downstream beat, with backpressure.
- Also reports the popcount of the word, so the checker's one-count can be cross-checked.

Parameters:
- DATA_W, 31, payload width; frame width FW = DATA_W+1.
- CNT_W, $clog2(DATA_W+1), width of the one-count output (5 at default).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_W  payload word.
- in_ready  out  1  transmitter can accept a word this cycle.
- tx_bit  out  1  current serial frame bit.
- tx_valid  out  1  tx_bit is valid.
- tx_ready  in  1  downstream consumes tx_bit this cycle.
- tx_last  out  1  tx_bit is the parity bit (frame bit 0).
- frame  out  FW  registered copy of the frame in flight: {data, parity}.
- one_count  out  CNT_W  popcount of the in-flight data word.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; tx_valid=0, tx_bit=0, tx_last=0, frame=0, one_count=0; bit index=FW-1. in_ready=1 once reset is released. Reset mid-frame aborts the frame; no partial bits follow.
- Accept: a word is accepted when in_valid && in_ready at a clk edge.
  - frame <= {in_data, ^in_data}, so the frame has an even total number of ones.
  - one_count <= popcount(in_data).
  - index <= FW-1; state <= SHIFT.
- IDLE: in_ready=1, tx_valid=0.
- SHIFT:
  - tx_valid=1; tx_bit=frame[index]; tx_last=(index==0).
  - Each cycle with tx_ready=1, the index decrements. With tx_ready=0, tx_bit, index and frame hold stable.
  - When tx_last && tx_ready, the state returns to IDLE unless a new word is accepted in the same cycle.
- in_ready = IDLE || (SHIFT && tx_last && tx_ready). This gives back-to-back frames with no gap cycle.
- Latency: the first frame bit is valid the cycle after acceptance. A frame takes FW consumed beats; minimum frame period is FW cycles.
- in_data changes while no word is accepted have no effect. frame and one_count hold until the next acceptance; they are not cleared on return to IDLE.
- tx_valid never drops mid-frame. Bits are never skipped or repeated regardless of the tx_ready pattern.

Optional Feature:
- Macro: EPARITY_TX_ERRINJ_EN.
- With the macro defined: extra input port err_inject (1 bit). If err_inject=1 at acceptance, the parity bit is inverted (frame[0] = ~^in_data), producing a deliberate parity error for checker testing. one_count is unaffected.
- Without the macro: the port is absent and parity is always correct even parity.

Test Plan:
- Reset, then in_data=31'h0000002A, tx_ready=1 -> one_count=3, frame=32'h00000055. Serial stream is 25 zeros, then 1,0,1,0,1,0,1. tx_last is high on the final 1. tx_valid is high for exactly 32 cycles.
- in_data=31'h00000155 -> one_count=5, frame=32'h000002AB, parity bit=1. Then in_data=31'h0 -> frame=0, parity=0, one_count=0.
- in_data=31'h7FFFFFFF -> one_count=31, frame=32'hFFFFFFFF. Then 31'h40000000 back-to-back with in_valid held -> in_ready pulses high on the last-bit cycle, and the second frame 32'h80000001 starts with no gap.
- Backpressure: random tx_ready (~50%) on in_data=31'h12345678 -> collected bits equal 32'h2468ACF1. tx_bit is stable while tx_ready=0, and in_ready stays 0 until the final beat.
- Reset mid-frame after 10 consumed bits -> next cycle tx_valid=0, frame=0, in_ready=1. A new word 31'h1 afterwards yields frame 32'h00000003.
- EPARITY_TX_ERRINJ_EN defined, in_data=31'h0000002A, err_inject=1 -> frame=32'h00000054, one_count=3. The frame fed to the 32-bit even-parity checker gives confirm=0.
